// File: rtl/g_bit.sv
// g_bit: clocked storage cell with change flag and saturating write counter.
// Optional `paridade` output (XOR of the stored value) when GBIT_PARITY_EN is defined.
module g_bit #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = 8
) (
  input  logic                 relogio,
  input  logic                 reinicio,
  input  logic [WIDTH-1:0]     dado,
  input  logic                 habilita,
  output logic [WIDTH-1:0]     resultado,
  output logic                 alterado,
  output logic [CNT_WIDTH-1:0] escritas
`ifdef GBIT_PARITY_EN
  ,
  output logic                 paridade
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     resultado_q, resultado_d;
  logic                 alterado_q, alterado_d;
  logic [CNT_WIDTH-1:0] escritas_q, escritas_d;

  always_comb begin
    resultado_d = resultado_q;
    alterado_d  = 1'b0;
    escritas_d  = escritas_q;
    if (habilita) begin
      resultado_d = dado;
      alterado_d  = (dado != resultado_q);
      // Counter sticks at all-ones; the data path keeps writing normally.
      if (escritas_q != CNT_MAX) begin
        escritas_d = escritas_q + 1'b1;
      end
    end
  end

  always_ff @(posedge relogio or posedge reinicio) begin
    if (reinicio) begin
      resultado_q <= RESET_VALUE;
      alterado_q  <= 1'b0;
      escritas_q  <= '0;
    end else begin
      resultado_q <= resultado_d;
      alterado_q  <= alterado_d;
      escritas_q  <= escritas_d;
    end
  end

  assign resultado = resultado_q;
  assign alterado  = alterado_q;
  assign escritas  = escritas_q;

`ifdef GBIT_PARITY_EN
  assign paridade = ^resultado_q;
`endif

endmodule

// File: tb/tb_g_bit.sv
// Bench for g_bit: two instances (1-bit/8-bit counter, 4-bit/2-bit counter) against a behavioural model.
module tb_g_bit;

  logic       clk;
  logic       reinicio;
  logic [0:0] dado_a;
  logic       hab_a;
  logic [0:0] res_a;
  logic       alt_a;
  logic [7:0] esc_a;
  logic [3:0] dado_b;
  logic       hab_b;
  logic [3:0] res_b;
  logic       alt_b;
  logic [1:0] esc_b;
`ifdef GBIT_PARITY_EN
  logic       par_a;
  logic       par_b;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state, derived from the behavioural rules of the cell
  logic [0:0] m_res_a;
  int         m_cnt_a;
  logic [3:0] m_res_b;
  int         m_cnt_b;
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;
  localparam logic [3:0] RV_B = 4'b0101;

  logic [16:0] exp_q[$];

  g_bit #(.WIDTH(1), .CNT_WIDTH(8)) dut_a (
    .relogio(clk), .reinicio(reinicio), .dado(dado_a), .habilita(hab_a),
    .resultado(res_a), .alterado(alt_a), .escritas(esc_a)
`ifdef GBIT_PARITY_EN
    , .paridade(par_a)
`endif
  );

  g_bit #(.WIDTH(4), .RESET_VALUE(RV_B), .CNT_WIDTH(2)) dut_b (
    .relogio(clk), .reinicio(reinicio), .dado(dado_b), .habilita(hab_b),
    .resultado(res_b), .alterado(alt_b), .escritas(esc_b)
`ifdef GBIT_PARITY_EN
    , .paridade(par_b)
`endif
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_res_a = 1'b0;
    m_cnt_a = 0;
    m_res_b = RV_B;
    m_cnt_b = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_res_a"}, {31'd0, res_a}, 32'd0);
    check({tag, "_alt_a"}, {31'd0, alt_a}, 32'd0);
    check({tag, "_esc_a"}, {24'd0, esc_a}, 32'd0);
    check({tag, "_res_b"}, {28'd0, res_b}, {28'd0, RV_B});
    check({tag, "_alt_b"}, {31'd0, alt_b}, 32'd0);
    check({tag, "_esc_b"}, {30'd0, esc_b}, 32'd0);
`ifdef GBIT_PARITY_EN
    check({tag, "_par_b"}, {31'd0, par_b}, 32'd0);
`endif
  endtask

  // Asynchronous reset between edges, then one enabled edge while reset is held
  task automatic async_reset();
    @(negedge clk);
    #2 reinicio = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check_reset("async");
    hab_a = 1'b1; dado_a = 1'b1; hab_b = 1'b1; dado_b = 4'b1111;
    @(posedge clk);
    #1 check_reset("held");
    @(negedge clk);
    reinicio = 1'b0;
    hab_a = 1'b0; hab_b = 1'b0;
  endtask

  // Driver: one clock cycle on both instances, scoreboarded against the model
  task automatic cycle(input logic en_a, input logic d_a, input logic en_b, input logic [3:0] d_b);
    logic        e_alt_a, e_alt_b;
    logic [16:0] e;
    @(negedge clk);
    hab_a = en_a; dado_a = d_a; hab_b = en_b; dado_b = d_b;
    e_alt_a = en_a && (d_a != m_res_a);
    if (en_a) begin
      m_res_a = d_a;
      if (m_cnt_a < MAX_A) m_cnt_a++;
    end
    e_alt_b = en_b && (d_b != m_res_b);
    if (en_b) begin
      m_res_b = d_b;
      if (m_cnt_b < MAX_B) m_cnt_b++;
    end
    exp_q.push_back({m_res_a, e_alt_a, 8'(m_cnt_a), m_res_b, e_alt_b, 2'(m_cnt_b)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("res_a", {31'd0, res_a}, {31'd0, e[16]});
    check("alt_a", {31'd0, alt_a}, {31'd0, e[15]});
    check("esc_a", {24'd0, esc_a}, {24'd0, e[14:7]});
    check("res_b", {28'd0, res_b}, {28'd0, e[6:3]});
    check("alt_b", {31'd0, alt_b}, {31'd0, e[2]});
    check("esc_b", {30'd0, esc_b}, {30'd0, e[1:0]});
`ifdef GBIT_PARITY_EN
    check("par_a", {31'd0, par_a}, {31'd0, ^e[16]});
    check("par_b", {31'd0, par_b}, {31'd0, ^e[6:3]});
`endif
    // Input activity between edges must not disturb any output
    #2;
    hab_a = 1'($urandom_range(1)); dado_a = 1'($urandom_range(1));
    hab_b = 1'($urandom_range(1)); dado_b = 4'($urandom_range(15));
    #1;
    check("stable_res_a", {31'd0, res_a}, {31'd0, e[16]});
    check("stable_esc_b", {30'd0, esc_b}, {30'd0, e[1:0]});
  endtask

  int sat_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    reinicio = 1'b0;
    hab_a = 1'b0; dado_a = 1'b0; hab_b = 1'b0; dado_b = 4'd0;
    model_reset();
    #2 reinicio = 1'b1;
    #1 check_reset("por");
    @(negedge clk);
    reinicio = 1'b0;

    // Hold: enable low, data toggling
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'(i % 2), 1'b0, 4'(i));
    check("hold_res_a", {31'd0, res_a}, 32'd0);
    check("hold_esc_a", {24'd0, esc_a}, 32'd0);

    // Single write, idle, redundant write
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    check("wr1_res", {31'd0, res_a}, 32'd1);
    check("wr1_alt", {31'd0, alt_a}, 32'd1);
    check("wr1_esc", {24'd0, esc_a}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    check("idle_alt", {31'd0, alt_a}, 32'd0);
    check("idle_res", {31'd0, res_a}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    check("redund_alt", {31'd0, alt_a}, 32'd0);
    check("redund_esc", {24'd0, esc_a}, 32'd2);

    async_reset();

    // Saturation on the 2-bit counter; parity pattern on the 4-bit data
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 4'b1011 : 4'b0011);
      check("sat_seq", {30'd0, esc_b}, 32'(sat_seq[i]));
`ifdef GBIT_PARITY_EN
      check("par_pat", {31'd0, par_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
    end

    // Randomized phase with occasional asynchronous resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(49) == 0) async_reset();
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    // Long write burst to saturate the 8-bit counter
    for (int i = 0; i < 260; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0, 4'd0);
    check("sat_a", {24'd0, esc_a}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
